// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch stage with PC register, IF/ID pipeline register and fetch FSM
// Ports: clk, rst (sync, active-high); stall freezes PC and IF/ID; flush/redirect_pc redirect fetch;
//   imem_req/imem_addr/imem_rdata/imem_ready instruction memory handshake;
//   if_id_pc/if_id_pc_plus4/if_id_inst/if_id_valid IF/ID register contents.
// Macro FETCH_HALT_EN: accepting ECALL/EBREAK parks the fetcher in HALT until a flush or reset.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_pc_plus4,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid
);
  logic [31:0] pc, pcPlus4;
  logic fetching, accept, take;
  assign pcPlus4 = pc + 32'd4;
  assign imem_addr = pc;
  assign imem_req = fetching;
  assign accept = fetching & imem_ready & ~stall & ~flush;
  assign take = accept & ~rst;
`ifdef FETCH_HALT_EN
  typedef enum logic {FETCH, HALT} state_t;
  state_t state, stateNext;
  always_ff @(posedge clk)
    state <= rst ? FETCH : stateNext;
  always_comb begin
    stateNext = state;
    if (flush) stateNext = FETCH;
    else if (accept && (imem_rdata == 32'h0000_0073 || imem_rdata == 32'h0010_0073)) stateNext = HALT;
  end
  assign fetching = state == FETCH;
`else
  assign fetching = 1'b1;
`endif
  // Any cycle not accepting a word (flush, memory wait, HALT) loads a bubble; stall alone freezes IF/ID.
  always_ff @(posedge clk) begin
    pc <= rst ? RESET_PC : flush ? redirect_pc : take ? pcPlus4 : pc;
    if (rst | flush | ~stall) begin
      if_id_pc       <= take ? pc : '0;
      if_id_pc_plus4 <= take ? pcPlus4 : '0;
      if_id_inst     <= take ? imem_rdata : NOP_INST;
      if_id_valid    <= take;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
  logic clk = 0, rst = 1, stall = 0, flush = 0, imem_ready = 1;
  logic [31:0] redirect_pc = '0, imem_rdata;
  logic imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_pc, if_id_pc_plus4, if_id_inst;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  fetch_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .if_id_pc(if_id_pc), .if_id_pc_plus4(if_id_pc_plus4), .if_id_inst(if_id_inst), .if_id_valid(if_id_valid)
  );
  function automatic logic [31:0] rom(input logic [31:0] a);
    case (a)
      32'h00: rom = 32'h0050_0093;
      32'h04: rom = 32'h0010_0113;
      32'h08: rom = 32'h0020_81b3;
      32'h0c: rom = 32'h0031_0233;
      32'h10: rom = 32'h0000_0073;
      32'h14: rom = 32'h0010_0073;
      default: rom = {16'hdead, a[15:0]};
    endcase
  endfunction
  assign imem_rdata = rom(imem_addr);
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chkIfId(input string tag, input logic [31:0] pc, input logic [31:0] pc4,
                         input logic [31:0] inst, input logic valid, input logic [31:0] addr);
    chk({tag, ".pc"}, if_id_pc, pc);
    chk({tag, ".pc4"}, if_id_pc_plus4, pc4);
    chk({tag, ".inst"}, if_id_inst, inst);
    chk({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, valid});
    chk({tag, ".addr"}, imem_addr, addr);
  endtask
  initial begin
    tick; tick;
    chkIfId("reset", 0, 0, 32'h13, 0, 0);
    chk("reset.req", {31'b0, imem_req}, 1);
    rst = 0;
    tick; chkIfId("first", 0, 4, 32'h0050_0093, 1, 4);
    chk("first.req", {31'b0, imem_req}, 1);
    tick; chkIfId("second", 4, 8, 32'h0010_0113, 1, 8);
    stall = 1;
    tick; chkIfId("stall1", 4, 8, 32'h0010_0113, 1, 8);
    tick; chkIfId("stall2", 4, 8, 32'h0010_0113, 1, 8);
    stall = 0;
    tick; chkIfId("unstall", 8, 12, 32'h0020_81b3, 1, 12);
    imem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick; chkIfId("wait", 0, 0, 32'h13, 0, 12);
      chk("wait.req", {31'b0, imem_req}, 1);
    end
    imem_ready = 1;
    tick; chkIfId("resume", 12, 16, 32'h0031_0233, 1, 16);
`ifdef FETCH_HALT_EN
    tick; chkIfId("ecall", 16, 20, 32'h73, 1, 20);
    chk("ecall.req", {31'b0, imem_req}, 0);
    tick; chkIfId("halt1", 0, 0, 32'h13, 0, 20);
    chk("halt1.req", {31'b0, imem_req}, 0);
    stall = 1;
    tick; chkIfId("haltstall", 0, 0, 32'h13, 0, 20);
    stall = 0; flush = 1; redirect_pc = 32'h0;
    tick; chkIfId("haltflush", 0, 0, 32'h13, 0, 0);
    chk("haltflush.req", {31'b0, imem_req}, 1);
    flush = 0;
    for (int i = 0; i < 5; i++) tick;
    chkIfId("ecall2", 16, 20, 32'h73, 1, 20);
    chk("ecall2.req", {31'b0, imem_req}, 0);
    rst = 1; flush = 1; redirect_pc = 32'h80;
    tick; chkIfId("halt.rst", 0, 0, 32'h13, 0, 0);
    chk("halt.rst.req", {31'b0, imem_req}, 1);
    rst = 0; flush = 0;
`else
    tick; chkIfId("ecall", 16, 20, 32'h73, 1, 20);
    chk("ecall.req", {31'b0, imem_req}, 1);
    tick; chkIfId("ebreak", 20, 24, 32'h0010_0073, 1, 24);
    chk("ebreak.req", {31'b0, imem_req}, 1);
`endif
    flush = 1; stall = 1; redirect_pc = 32'h40;
    tick; chkIfId("flushstall", 0, 0, 32'h13, 0, 32'h40);
    flush = 0; stall = 0;
    tick; chkIfId("target", 32'h40, 32'h44, 32'hdead_0040, 1, 32'h44);
    flush = 1; redirect_pc = 32'hffff_fffc;
    tick; chkIfId("towrap", 0, 0, 32'h13, 0, 32'hffff_fffc);
    flush = 0;
    tick; chkIfId("wrap", 32'hffff_fffc, 0, 32'hdead_fffc, 1, 0);
    flush = 1; redirect_pc = 32'h30;
    tick; flush = 0; imem_ready = 0;
    tick; chkIfId("wait30", 0, 0, 32'h13, 0, 32'h30);
    rst = 1; stall = 1;
    tick; chkIfId("wait.rst", 0, 0, 32'h13, 0, 0);
    chk("wait.rst.req", {31'b0, imem_req}, 1);
    rst = 0; stall = 0; imem_ready = 1;
    tick; chkIfId("after.rst", 0, 4, 32'h0050_0093, 1, 4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), giving the bubble encoding.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port stall  input  1  load-use stall from hazard detection; freezes PC and IF/ID.
REQ-006 The block SHALL have port flush  input  1  taken branch or jump resolved downstream; redirects fetch.
REQ-007 The block SHALL have port redirect_pc  input  32  target address, valid when flush=1.
REQ-008 The block SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-009 The block SHALL have port imem_addr  output  32  fetch address, equal to the current PC.
REQ-010 The block SHALL have port imem_rdata  input  32  instruction word, valid when imem_ready=1.
REQ-011 The block SHALL have port imem_ready  input  1  memory response this cycle for the current imem_addr.
REQ-012 The block SHALL have ports if_id_pc, if_id_pc_plus4, if_id_inst  output  32 each  IF/ID register contents.
REQ-013 The block SHALL have port if_id_valid  output  1  IF/ID holds a real instruction (0 = bubble).

Function
REQ-014 The block SHALL implement a 2-state FSM: FETCH (imem_req=1) and HALT (imem_req=0).
REQ-015 imem_addr SHALL always equal the PC register combinationally.
REQ-016 An instruction SHALL be accepted when state=FETCH, imem_ready=1, stall=0 and flush=0.
REQ-017 On accept, the block SHALL load IF/ID with {PC, PC+4, imem_rdata, valid=1} and set PC<=PC+4, 32-bit wrap (32'hFFFF_FFFC -> 32'h0).
REQ-018 In FETCH with imem_ready=0, stall=0 and flush=0, the block SHALL load IF/ID with a bubble (inst=NOP_INST, valid=0, pc fields 0) and hold PC.
REQ-019 When stall=1 and flush=0, the block SHALL hold PC and all IF/ID outputs unchanged, while imem_req stays at its state value; returned data is discarded and refetched.
REQ-020 When flush=1, the block SHALL set PC<=redirect_pc, load an IF/ID bubble and go to FETCH, overriding stall, imem_ready and HALT.
REQ-021 Accepted-instruction latency SHALL be one cycle: data at edge N appears on if_id_* after edge N.
REQ-022 In HALT, the block SHALL hold PC, and load an IF/ID bubble every cycle unless stall=1.

Reset
REQ-023 When rst=1 at a clock edge, the block SHALL set PC=RESET_PC, state=FETCH, if_id_inst=NOP_INST, if_id_valid=0, if_id_pc=0, if_id_pc_plus4=0.
REQ-024 rst SHALL take priority over flush, stall and imem_ready, including mid-wait and in HALT.
REQ-025 imem_req SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-026 With macro FETCH_HALT_EN defined, accepting ECALL (32'h0000_0073) or EBREAK (32'h0010_0073) SHALL move the FSM to HALT after the accept edge, with PC pointing past it.
REQ-027 Without FETCH_HALT_EN, the HALT state SHALL be absent, imem_req SHALL be constant 1 outside reset, and ECALL/EBREAK SHALL be fetched as ordinary instructions.

Verification
REQ-028 The bench SHALL test reset with imem_ready=1 and rdata=32'h0050_0093 -> cycle 1: if_id_pc=0, if_id_inst=32'h0050_0093, valid=1, PC=4.
REQ-029 The bench SHALL test stall=1 for 2 cycles at PC=8 -> PC stays 8, if_id_* unchanged both cycles; after release the word at 8 is accepted.
REQ-030 The bench SHALL test flush=1 with redirect_pc=32'h40 and stall=1 together -> next cycle PC=32'h40, valid=0, if_id_inst=32'h13.
REQ-031 The bench SHALL test imem_ready=0 for 3 cycles at PC=12 -> 3 bubbles, PC stays 12, imem_req=1 throughout.
REQ-032 The bench SHALL test FETCH_HALT_EN with ECALL at PC=16 -> ECALL in IF/ID, then imem_req=0, PC=20, bubbles; flush to 32'h0 resumes FETCH.
REQ-033 The bench SHALL test rst during HALT and during an imem_ready=0 wait -> PC=RESET_PC, state FETCH, valid=0 next cycle.
